// File: rtl/issue_scheduler.sv
// Scoreboard-based issue controller sitting between decode and the functional units.
// Tracks a busy bit per architectural register and reserves the single writeback port
// through a shift register. Branches are serialised (no issue until resolved). A drain
// request stops issue until all writebacks have retired.
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   inValid             decoded instruction presented this cycle
//   rs1, rs2, rd        source / destination register indices
//   useRs1, useRs2      instruction reads rs1 / rs2
//   writesRd            instruction writes rd
//   lat                 FU latency (0 -> 1, >MAXLAT -> MAXLAT)
//   isBranch            instruction is a branch/jump
//   brResolved, brTaken branch outcome (only meaningful while waiting on a branch)
//   drainReq            drain request, sampled while running
//   issue, stall        combinational accept / reject of the presented instruction
//   hazard              combinational RAW hazard flags {rs2, rs1}
//   wbValid, wbRd       registered writeback slot for this cycle
//   redirect            registered pulse: taken branch resolved
//   drainDone           registered pulse: drain complete
module issue_scheduler #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned MAXLAT = 8,
  parameter int unsigned LATW   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inValid,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic            useRs1,
  input  logic            useRs2,
  input  logic            writesRd,
  input  logic [LATW-1:0] lat,
  input  logic            isBranch,
  input  logic            brResolved,
  input  logic            brTaken,
  input  logic            drainReq,
  output logic            issue,
  output logic            stall,
  output logic [1:0]      hazard,
  output logic            wbValid,
  output logic [4:0]      wbRd,
  output logic            redirect,
  output logic            drainDone
);

  localparam int unsigned IDXW = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;
  localparam int unsigned EXTW = $clog2(MAXLAT + 1);

  localparam logic [1:0] StRun    = 2'd0;
  localparam logic [1:0] StBrWait = 2'd1;
  localparam logic [1:0] StDrain  = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [NREGS-1:0]        busy_q, busy_d;
  // Slot k holds the writeback due k cycles from now; slot 0 drives the wb outputs.
  logic [MAXLAT-1:0]       res_v_q, res_v_d;
  logic [MAXLAT-1:0][4:0]  res_rd_q, res_rd_d;
  logic                    redirect_q, redirect_d;
  logic                    drain_done_q, drain_done_d;

  logic [LATW-1:0]         lat_eff;
  logic [LATW-1:0]         lat_m1;
  logic [MAXLAT:0]         res_ext;
  logic                    wb_conflict;
  logic                    wr_en;
  logic                    alloc;
  logic                    drain_clear;

  always_comb begin
    if (lat == '0) begin
      lat_eff = LATW'(1);
    end else if (lat > LATW'(MAXLAT)) begin
      lat_eff = LATW'(MAXLAT);
    end else begin
      lat_eff = lat;
    end
  end

  assign lat_m1 = lat_eff - LATW'(1);

  // Slot MAXLAT is never occupied at the moment of checking, hence the zero pad.
  assign res_ext     = {1'b0, res_v_q};
  assign wb_conflict = res_ext[lat_eff[EXTW-1:0]];

  assign wr_en  = writesRd && (rd != 5'd0);
  assign hazard = {useRs2 & busy_q[rs2], useRs1 & busy_q[rs1]};
  assign issue  = inValid && (state_q == StRun) && (hazard == 2'b00) &&
                  !(wr_en && (busy_q[rd] || wb_conflict));
  assign stall  = inValid & ~issue;
  assign alloc  = issue & wr_en;

  // Reservation shift plus new allocation.
  always_comb begin
    res_v_d  = '0;
    res_rd_d = '0;
    for (int k = 0; k < int'(MAXLAT) - 1; k++) begin
      res_v_d[k]  = res_v_q[k+1];
      res_rd_d[k] = res_rd_q[k+1];
    end
    if (alloc) begin
      res_v_d[lat_m1[IDXW-1:0]]  = 1'b1;
      res_rd_d[lat_m1[IDXW-1:0]] = rd;
    end
  end

  // Retire clears and issue sets hit different registers (WAW stall guarantees it).
  always_comb begin
    busy_d = busy_q;
    if (res_v_q[0]) begin
      busy_d[res_rd_q[0]] = 1'b0;
    end
    if (alloc) begin
      busy_d[rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Looking at next-state lets drainDone land in the cycle right after the last retire.
  assign drain_clear = (busy_d == '0) && (res_v_d == '0);

  always_comb begin
    state_d      = state_q;
    redirect_d   = 1'b0;
    drain_done_d = 1'b0;
    case (state_q)
      StRun: begin
        if (issue && isBranch) begin
          state_d = StBrWait;
        end else if (drainReq && !issue) begin
          state_d = StDrain;
        end
      end
      StBrWait: begin
        if (brResolved) begin
          state_d    = StRun;
          redirect_d = brTaken;
        end
      end
      StDrain: begin
        if (drain_clear) begin
          state_d      = StRun;
          drain_done_d = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StRun;
      busy_q       <= '0;
      res_v_q      <= '0;
      res_rd_q     <= '0;
      redirect_q   <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      res_v_q      <= res_v_d;
      res_rd_q     <= res_rd_d;
      redirect_q   <= redirect_d;
      drain_done_q <= drain_done_d;
    end
  end

  assign wbValid   = res_v_q[0];
  assign wbRd      = res_rd_q[0];
  assign redirect  = redirect_q;
  assign drainDone = drain_done_q;

endmodule
